// File: rtl/data_mem_if.sv
// Load/store request and response channels between the load/store path (master)
// and the data memory responder (slave).
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_byte;
  logic        req_is_word;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_is_load;
  logic        resp_error;

  modport master (
    output req_valid, req_is_load, req_is_byte, req_is_word, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_is_load, resp_error
  );

  modport slave (
    input  req_valid, req_is_load, req_is_byte, req_is_word, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_is_load, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data RAM responder: accepts one load/store at a time, commits it after a fixed
// latency and holds the response until the consumer takes it.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 15,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  mem_bus,
  output logic       busy
);
  localparam int         WORDS    = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        req_ready_q, resp_valid_q, resp_is_load_q, resp_error_q, busy_q;
  logic [31:0] resp_rdata_q;

  logic        lat_is_load, lat_is_byte, lat_is_word;
  logic [31:0] lat_addr, lat_wdata;

  logic        accept, do_access, acc_err;
  logic        acc_is_load, acc_is_byte, acc_is_word;
  logic [31:0] acc_addr, acc_wdata;
  logic [ADDR_WIDTH-3:0] acc_idx;
  logic [1:0]  acc_lane;

  logic [31:0] mem [WORDS];

  function automatic logic access_error(input logic is_byte, input logic is_word,
                                        input logic [31:0] addr);
    return (is_byte == is_word) || (is_word && (addr[1:0] != 2'b00)) ||
           ((addr >> ADDR_WIDTH) != 32'd0);
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [1:0] lane,
                                             input logic is_byte);
    logic signed [7:0]  lane_byte;
    logic signed [31:0] ext;
    lane_byte = word[{lane, 3'b000} +: 8];
    ext       = lane_byte;
    return is_byte ? ext : word;
  endfunction

  // With LATENCY=1 the access happens on the accept edge, straight from the request inputs.
  always_comb begin
    accept      = mem_bus.req_valid && req_ready_q;
    acc_is_load = lat_is_load;
    acc_is_byte = lat_is_byte;
    acc_is_word = lat_is_word;
    acc_addr    = lat_addr;
    acc_wdata   = lat_wdata;
    do_access   = 1'b0;
    if (state == IDLE) begin
      acc_is_load = mem_bus.req_is_load;
      acc_is_byte = mem_bus.req_is_byte;
      acc_is_word = mem_bus.req_is_word;
      acc_addr    = mem_bus.req_addr;
      acc_wdata   = mem_bus.req_wdata;
      do_access   = accept && (CNT_INIT == 4'd0);
    end else if (state == WAIT) begin
      do_access   = (cnt == 4'd1);
    end
    acc_err  = access_error(acc_is_byte, acc_is_word, acc_addr);
    acc_idx  = acc_addr[ADDR_WIDTH-1:2];
    acc_lane = acc_addr[1:0];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_is_load <= mem_bus.req_is_load;
      lat_is_byte <= mem_bus.req_is_byte;
      lat_is_word <= mem_bus.req_is_word;
      lat_addr    <= mem_bus.req_addr;
      lat_wdata   <= mem_bus.req_wdata;
    end
  end

  // Store commit; a reset on the commit edge drops the pending store.
  always_ff @(posedge clk) begin
    if (do_access && !acc_is_load && !acc_err && !reset) begin
      if (acc_is_word) begin
        mem[acc_idx] <= acc_wdata;
      end else begin
        for (int l = 0; l < 4; l++) begin
          if (acc_lane == 2'(l)) mem[acc_idx][8*l +: 8] <= acc_wdata[7:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'd0;
      resp_is_load_q <= 1'b0;
      resp_error_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt         <= CNT_INIT;
          req_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          if (CNT_INIT == 4'd0) state <= RESP;
          else                  state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (mem_bus.resp_ready) begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (do_access) begin
        resp_valid_q   <= 1'b1;
        resp_is_load_q <= acc_is_load;
        resp_error_q   <= acc_err;
        resp_rdata_q   <= (acc_err || !acc_is_load) ? 32'd0 :
                          load_value(mem[acc_idx], acc_lane, acc_is_byte);
      end
    end
  end

  assign mem_bus.req_ready    = req_ready_q;
  assign mem_bus.resp_valid   = resp_valid_q;
  assign mem_bus.resp_rdata   = resp_rdata_q;
  assign mem_bus.resp_is_load = resp_is_load_q;
  assign mem_bus.resp_error   = resp_error_q;
  assign busy                 = busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, random ops against a byte-array
// model, and multi-cycle sequences (backpressure, reset abort, LATENCY=1 streaming).
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy2, busy1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_mem_if if2 ();
  data_mem_if if1 ();

  data_mem_responder #(.ADDR_WIDTH(15), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .mem_bus(if2), .busy(busy2));
  data_mem_responder #(.ADDR_WIDTH(15), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_bus(if1), .busy(busy1));

  typedef struct {
    bit          ld, byt, wrd;
    logic [31:0] addr, wdata, exp_rd;
    bit          exp_err;
  } vec_t;

  logic [7:0] mb [32768];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: byte-addressed memory, errors computed from the address rules.
  function automatic void model(input bit ld, input bit byt, input bit wrd,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output bit er);
    logic [14:0] i;
    byte         sb;
    i  = a[14:0];
    er = (byt == wrd) || (wrd && a % 4 != 0) || (a >= 32'h8000);
    rd = 32'd0;
    if (er) return;
    if (ld) begin
      if (byt) begin
        sb = mb[i];
        rd = 32'(int'(sb));
      end else begin
        rd = {mb[i+3], mb[i+2], mb[i+1], mb[i]};
      end
    end else if (byt) begin
      mb[i] = wd[7:0];
    end else begin
      for (int k = 0; k < 4; k++) mb[i + 15'(k)] = wd[8*k +: 8];
    end
  endfunction

  task automatic req2(input bit ld, input bit byt, input bit wrd, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output bit er,
                      output bit isld, output int lat);
    int n;
    rd = 32'd0; er = 1'b0; isld = 1'b0; lat = -1;
    @(negedge clk);
    if2.req_valid = 1'b1; if2.req_is_load = ld; if2.req_is_byte = byt;
    if2.req_is_word = wrd; if2.req_addr = addr; if2.req_wdata = wdata;
    n = 0;
    while (!if2.req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin if2.req_valid = 1'b0; timeout("req_ready"); return; end
    @(posedge clk);
    @(negedge clk);
    if2.req_valid = 1'b0;
    lat = 0;
    while (!if2.resp_valid && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
    if (lat >= 40) begin timeout("resp_valid"); return; end
    rd = if2.resp_rdata; er = if2.resp_error; isld = if2.resp_is_load;
    if2.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if2.resp_ready = 1'b0;
  endtask

  initial begin
    vec_t        vt[$];
    logic [31:0] rd, mrd, held;
    bit          er, merr, isld;
    int          lat, n;
    logic [31:0] w1 [4];
    logic [31:0] exq[$];
    int          issued, nresp, last_resp, cyc;
    bit          ld, byt, wrd;
    logic [31:0] addr, wdata;

    if2.req_valid = 0; if2.req_is_load = 0; if2.req_is_byte = 0; if2.req_is_word = 0;
    if2.req_addr = 0; if2.req_wdata = 0; if2.resp_ready = 0;
    if1.req_valid = 0; if1.req_is_load = 0; if1.req_is_byte = 0; if1.req_is_word = 0;
    if1.req_addr = 0; if1.req_wdata = 0; if1.resp_ready = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(if2.req_ready), 32'd1);
    check("rst_resp_valid", 32'(if2.resp_valid), 32'd0);
    check("rst_resp_rdata", if2.resp_rdata, 32'd0);
    check("rst_resp_is_load", 32'(if2.resp_is_load), 32'd0);
    check("rst_resp_error", 32'(if2.resp_error), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_l1_req_ready", 32'(if1.req_ready), 32'd1);
    reset = 1'b0;

    vt.push_back('{0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 0});
    vt.push_back('{1, 0, 1, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0});
    vt.push_back('{0, 0, 1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0});
    vt.push_back('{0, 1, 0, 32'h0000_0103, 32'h0000_0080, 32'h0000_0000, 0});
    vt.push_back('{1, 1, 0, 32'h0000_0103, 32'h0000_0000, 32'hFFFF_FF80, 0});
    vt.push_back('{1, 0, 1, 32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 0});
    vt.push_back('{1, 0, 1, 32'h0000_0102, 32'h0000_0000, 32'h0000_0000, 1});
    vt.push_back('{1, 0, 1, 32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 1});
    vt.push_back('{0, 1, 1, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 1});
    vt.push_back('{0, 0, 0, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 1});
    vt.push_back('{0, 0, 1, 32'h0000_8100, 32'h1234_5678, 32'h0000_0000, 1});
    vt.push_back('{1, 0, 1, 32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 0});
    vt.push_back('{1, 1, 0, 32'h0000_0101, 32'h0000_0000, 32'h0000_0000, 0});
    vt.push_back('{0, 1, 0, 32'h0000_0101, 32'hAAAA_AA7F, 32'h0000_0000, 0});
    vt.push_back('{1, 1, 0, 32'h0000_0101, 32'h0000_0000, 32'h0000_007F, 0});
    vt.push_back('{1, 0, 1, 32'h0000_0100, 32'h0000_0000, 32'h8000_7F00, 0});
    vt.push_back('{0, 1, 0, 32'h0000_8003, 32'h0000_0011, 32'h0000_0000, 1});
    vt.push_back('{0, 0, 1, 32'h0000_7FFC, 32'hCAFE_F00D, 32'h0000_0000, 0});
    vt.push_back('{1, 0, 1, 32'h0000_7FFC, 32'h0000_0000, 32'hCAFE_F00D, 0});
    vt.push_back('{1, 1, 0, 32'h0000_7FFE, 32'h0000_0000, 32'hFFFF_FFFE, 0});

    foreach (vt[i]) begin
      model(vt[i].ld, vt[i].byt, vt[i].wrd, vt[i].addr, vt[i].wdata, mrd, merr);
      req2(vt[i].ld, vt[i].byt, vt[i].wrd, vt[i].addr, vt[i].wdata, rd, er, isld, lat);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_error", i), 32'(er), 32'(vt[i].exp_err));
      check($sformatf("vec%0d_is_load", i), 32'(isld), 32'(vt[i].ld));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
    end

    // Random traffic over a prefilled window.
    for (int k = 0; k < 16; k++) begin
      wdata = $urandom();
      model(0, 0, 1, 32'h400 + 32'(4*k), wdata, mrd, merr);
      req2(0, 0, 1, 32'h400 + 32'(4*k), wdata, rd, er, isld, lat);
      check("fill_error", 32'(er), 32'd0);
    end
    for (int k = 0; k < 150; k++) begin
      n   = $urandom_range(0, 9);
      ld  = 1'($urandom_range(0, 1));
      byt = (n == 0) || (n >= 2 && n < 6);
      wrd = (n == 0) || (n >= 6);
      addr = 32'h400 + 32'($urandom_range(0, 63));
      if (wrd && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) addr = addr | (32'h1 << $urandom_range(15, 31));
      wdata = $urandom();
      model(ld, byt, wrd, addr, wdata, mrd, merr);
      req2(ld, byt, wrd, addr, wdata, rd, er, isld, lat);
      check($sformatf("rnd%0d_rdata", k), rd, mrd);
      check($sformatf("rnd%0d_error", k), 32'(er), 32'(merr));
    end

    // Backpressure: response held 5 cycles, a second request must be ignored.
    model(1, 0, 1, 32'h100, 32'd0, mrd, merr);
    @(negedge clk);
    if2.req_valid = 1'b1; if2.req_is_load = 1'b1; if2.req_is_byte = 1'b0;
    if2.req_is_word = 1'b1; if2.req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    if2.req_valid = 1'b0;
    n = 0;
    while (!if2.resp_valid && n < 40) begin @(posedge clk); @(negedge clk); n++; end
    if (n >= 40) timeout("hold_resp_valid");
    held = if2.resp_rdata;
    check("hold_first_rdata", held, mrd);
    if2.req_valid = 1'b1; if2.req_is_load = 1'b0; if2.req_is_word = 1'b1;
    if2.req_addr = 32'h100; if2.req_wdata = 32'h1111_1111;
    for (int k = 0; k < 5; k++) begin
      check("hold_resp_valid", 32'(if2.resp_valid), 32'd1);
      check("hold_rdata", if2.resp_rdata, held);
      check("hold_req_ready", 32'(if2.req_ready), 32'd0);
      check("hold_busy", 32'(busy2), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    if2.req_valid = 1'b0;
    if2.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if2.resp_ready = 1'b0;
    check("handoff_resp_valid", 32'(if2.resp_valid), 32'd0);
    check("handoff_req_ready", 32'(if2.req_ready), 32'd1);
    check("handoff_busy", 32'(busy2), 32'd0);
    req2(1, 0, 1, 32'h100, 32'd0, rd, er, isld, lat);
    check("ignored_store_rdata", rd, mrd);

    // Reset on the commit edge drops the store and its response.
    @(negedge clk);
    if2.req_valid = 1'b1; if2.req_is_load = 1'b0; if2.req_is_byte = 1'b0;
    if2.req_is_word = 1'b1; if2.req_addr = 32'h100; if2.req_wdata = 32'h55AA_55AA;
    @(posedge clk);
    @(negedge clk);
    if2.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_resp_valid", 32'(if2.resp_valid), 32'd0);
    check("abort_req_ready", 32'(if2.req_ready), 32'd1);
    check("abort_busy", 32'(busy2), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_resp", 32'(if2.resp_valid), 32'd0);
    end
    req2(1, 0, 1, 32'h100, 32'd0, rd, er, isld, lat);
    check("abort_old_value", rd, mrd);

    // LATENCY=1 streaming with resp_ready tied high.
    w1[0] = 32'hC012_3456; w1[1] = 32'h8765_4321; w1[2] = 32'h0F0F_A5A5; w1[3] = 32'h7FFF_0001;
    issued = 0; nresp = 0; last_resp = -1; cyc = 0;
    while (nresp < 8 && cyc < 80) begin
      @(negedge clk);
      if (if1.resp_valid) begin
        if (exq.size() > 0) check($sformatf("l1_resp%0d_rdata", nresp), if1.resp_rdata, exq.pop_front());
        else timeout("l1_unexpected_resp");
        check($sformatf("l1_resp%0d_is_load", nresp), 32'(if1.resp_is_load), 32'(nresp >= 4));
        if (last_resp >= 0) check($sformatf("l1_resp%0d_gap", nresp), 32'(cyc - last_resp), 32'd2);
        last_resp = cyc;
        nresp++;
      end
      if (issued < 8) begin
        if1.req_valid = 1'b1; if1.req_is_byte = 1'b0; if1.req_is_word = 1'b1;
        if1.req_is_load = (issued >= 4);
        if1.req_addr  = (issued < 4) ? 32'h10 + 32'(4*issued) : 32'h10 + 32'(4*(7-issued));
        if1.req_wdata = (issued < 4) ? w1[issued] : 32'd0;
        if (if1.req_ready) begin
          exq.push_back((issued < 4) ? 32'd0 : w1[7-issued]);
          issued++;
        end
      end else begin
        if1.req_valid = 1'b0;
      end
      cyc++;
    end
    if (nresp < 8) timeout("l1_stream");
    if1.req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
